collatz_sweep: RTL

Parametrised multi-lane Collatz range sweeper; the next generation of the single-engine range block. On a `go` rising edge it computes the Collatz sequence length for `RAM_WORDS` consecutive start values, spread across `LANES` parallel iteration lanes. Each result is written into an internal count RAM that the host reads back through a registered read port. It also reports the longest sequence found, with its start value, and sticky overflow and saturation flags.

---
 rtl/collatz_pkg.sv | 40 ++++
 rtl/collatz_lane.sv | 135 +++++++++++++
 rtl/collatz_sweep.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared types and helpers for the multi-lane Collatz range sweeper.
package collatz_pkg;

  // Per-lane iteration state
  typedef enum logic [1:0] {
    LANE_FREE = 2'd0,
    LANE_ITER = 2'd1,
    LANE_HOLD = 2'd2
  } lane_state_e;

  // Sweep-level control state
  typedef enum logic [1:0] {
    TOP_IDLE = 2'd0,
    TOP_RUN  = 2'd1,
    TOP_FIN  = 2'd2
  } top_state_e;

  // Result of a lowest-index-wins priority encode over up to eight requesters
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  // Lowest set bit wins; used for both lane dispatch and write grant
  function automatic prio_t prio_enc(input logic [7:0] i_req);
    prio_t r_sel;
    r_sel.valid = 1'b0;
    r_sel.idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (i_req[k]) begin
        r_sel.valid = 1'b1;
        r_sel.idx   = 3'(k);
      end else begin
        r_sel = r_sel;
      end
    end
    return r_sel;
  endfunction

endpackage

// File: rtl/collatz_lane.sv
// One Collatz iteration lane: loads a start value, iterates to 1 (or to an
// overflow/saturation stop), then holds its result until the write port is granted.
module collatz_lane
  import collatz_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter int COUNT_BITS = 16,
  parameter int TAG_BITS   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [N_BITS-1:0]     i_n_in,
  input  logic [TAG_BITS-1:0]   i_tag_in,
  input  logic                  i_grant,
  output logic                  o_hold,
  output logic [COUNT_BITS-1:0] o_result,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic                  o_ovf,
  output logic                  o_sat
);

  lane_state_e             r_state;
  logic [N_BITS-1:0]       r_n;
  logic [COUNT_BITS-1:0]   r_cnt;
  logic [COUNT_BITS-1:0]   r_result;
  logic [TAG_BITS-1:0]     r_tag;
  logic                    r_ovf;
  logic                    r_sat;

  lane_state_e             w_state_nxt;
  logic [N_BITS-1:0]       w_n_nxt;
  logic [COUNT_BITS-1:0]   w_cnt_nxt;
  logic [COUNT_BITS-1:0]   w_result_nxt;
  logic                    w_ovf_nxt;
  logic                    w_sat_nxt;
  logic [N_BITS+1:0]       w_3n1;
  logic                    w_cnt_max;

  // 3n+1 at two extra bits so an escape past N_BITS is visible
  assign w_3n1     = {2'b00, r_n} + {1'b0, r_n, 1'b0} + {{(N_BITS+1){1'b0}}, 1'b1};
  assign w_cnt_max = &r_cnt;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= LANE_FREE;
      r_n      <= {N_BITS{1'b0}};
      r_cnt    <= {COUNT_BITS{1'b0}};
      r_result <= {COUNT_BITS{1'b0}};
      r_tag    <= {TAG_BITS{1'b0}};
      r_ovf    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_sat    <= w_sat_nxt;
      if ((r_state == LANE_FREE) && i_load) begin
        r_tag <= i_tag_in;
      end else begin
        r_tag <= r_tag;
      end
    end
  end

  // Next state and next iterate; n==0 stops immediately so it cannot hang
  always_comb begin
    w_state_nxt  = r_state;
    w_n_nxt      = r_n;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_sat_nxt    = r_sat;
    case (r_state)
      LANE_FREE: begin
        if (i_load) begin
          w_state_nxt  = LANE_ITER;
          w_n_nxt      = i_n_in;
          w_cnt_nxt    = {{(COUNT_BITS-1){1'b0}}, 1'b1};
          w_result_nxt = {COUNT_BITS{1'b0}};
          w_ovf_nxt    = 1'b0;
          w_sat_nxt    = 1'b0;
        end else begin
          w_state_nxt = LANE_FREE;
        end
      end
      LANE_ITER: begin
        if (r_n == {{(N_BITS-1){1'b0}}, 1'b1}) begin
          w_state_nxt  = LANE_HOLD;
          w_result_nxt = r_cnt;
        end else if (r_n == {N_BITS{1'b0}}) begin
          w_state_nxt  = LANE_HOLD;
          w_result_nxt = {COUNT_BITS{1'b0}};
        end else if (r_n[0] && (w_3n1[N_BITS+1:N_BITS] != 2'b00)) begin
          w_state_nxt  = LANE_HOLD;
          w_result_nxt = {COUNT_BITS{1'b1}};
          w_ovf_nxt    = 1'b1;
        end else if (w_cnt_max) begin
          w_state_nxt  = LANE_HOLD;
          w_result_nxt = {COUNT_BITS{1'b1}};
          w_sat_nxt    = 1'b1;
        end else if (r_n[0]) begin
          w_n_nxt   = w_3n1[N_BITS-1:0];
          w_cnt_nxt = r_cnt + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        end else begin
          w_n_nxt   = {1'b0, r_n[N_BITS-1:1]};
          w_cnt_nxt = r_cnt + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        end
      end
      LANE_HOLD: begin
        if (i_grant) begin
          w_state_nxt = LANE_FREE;
        end else begin
          w_state_nxt = LANE_HOLD;
        end
      end
      default: begin
        w_state_nxt = LANE_FREE;
      end
    endcase
  end

  // Outputs straight from registered state
  always_comb begin
    o_hold   = (r_state == LANE_HOLD);
    o_result = r_result;
    o_tag    = r_tag;
    o_ovf    = r_ovf;
    o_sat    = r_sat;
  end

endmodule

// File: rtl/collatz_sweep.sv
// Multi-lane Collatz range sweeper: dispatches RAM_WORDS consecutive start
// values to LANES iteration lanes, stores each sequence length in a count RAM,
// and tracks the longest sequence plus sticky overflow/saturation flags.
module collatz_sweep
  import collatz_pkg::*;
#(
  parameter int N_BITS        = 32,
  parameter int COUNT_BITS    = 16,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4,
  parameter int LANES         = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_go,
  input  logic [N_BITS-1:0]        i_start,
  input  logic [RAM_ADDR_BITS-1:0] i_rd_addr,
  output logic [COUNT_BITS-1:0]    o_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [COUNT_BITS-1:0]    o_max_count,
  output logic [N_BITS-1:0]        o_max_start,
  output logic                     o_overflow,
  output logic                     o_saturated
);

  localparam int                  IDX_BITS = RAM_ADDR_BITS + 1;
  localparam logic [IDX_BITS-1:0] WORDS_L  = IDX_BITS'(RAM_WORDS);
  localparam logic [IDX_BITS-1:0] LAST_L   = IDX_BITS'(RAM_WORDS - 1);

  top_state_e                r_state;
  logic                      r_go_q;
  logic [N_BITS-1:0]         r_base;
  logic [IDX_BITS-1:0]       r_idx;
  logic [IDX_BITS-1:0]       r_wr_cnt;
  logic [LANES-1:0]          r_lane_busy;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_overflow;
  logic                      r_saturated;
  logic [COUNT_BITS-1:0]     r_max_count;
  logic [N_BITS-1:0]         r_max_start;
  logic [COUNT_BITS-1:0]     r_count;
  logic [COUNT_BITS-1:0]     r_mem [RAM_WORDS];

  top_state_e                w_state_nxt;
  logic                      w_go_rise;
  logic [7:0]                w_hold_pad;
  logic [7:0]                w_free_pad;
  prio_t                     w_wr_sel;
  prio_t                     w_disp_sel;
  logic                      w_dispatch;
  logic                      w_wr_valid;
  logic                      w_last_write;
  logic [LANES-1:0]          w_load;
  logic [LANES-1:0]          w_grant;
  logic [LANES-1:0]          w_hold;
  logic [LANES-1:0]          w_ovf;
  logic [LANES-1:0]          w_sat;
  logic [COUNT_BITS-1:0]     w_result [LANES];
  logic [RAM_ADDR_BITS-1:0]  w_tag [LANES];
  logic [COUNT_BITS-1:0]     w_wr_result;
  logic [RAM_ADDR_BITS-1:0]  w_wr_tag;
  logic                      w_wr_ovf;
  logic                      w_wr_sat;
  logic [N_BITS-1:0]         w_n_in;
  logic [RAM_ADDR_BITS-1:0]  w_tag_in;

  assign w_go_rise    = i_go & ~r_go_q;
  assign w_n_in       = r_base + N_BITS'(r_idx);
  assign w_tag_in     = r_idx[RAM_ADDR_BITS-1:0];
  assign w_last_write = w_wr_valid && (r_wr_cnt == LAST_L);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    collatz_lane #(
      .N_BITS    (N_BITS),
      .COUNT_BITS(COUNT_BITS),
      .TAG_BITS  (RAM_ADDR_BITS)
    ) u_lane (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load[g]),
      .i_n_in  (w_n_in),
      .i_tag_in(w_tag_in),
      .i_grant (w_grant[g]),
      .o_hold  (w_hold[g]),
      .o_result(w_result[g]),
      .o_tag   (w_tag[g]),
      .o_ovf   (w_ovf[g]),
      .o_sat   (w_sat[g])
    );
  end

  // Dispatch to lowest FREE lane and grant the write port to lowest HOLD lane
  always_comb begin
    w_hold_pad                = 8'd0;
    w_hold_pad[LANES-1:0]     = w_hold;
    w_free_pad                = 8'd0;
    w_free_pad[LANES-1:0]     = ~r_lane_busy;
    w_wr_sel                  = prio_enc(w_hold_pad);
    w_disp_sel                = prio_enc(w_free_pad);
    w_dispatch                = (r_state == TOP_RUN) && (r_idx < WORDS_L) && w_disp_sel.valid;
    w_wr_valid                = w_wr_sel.valid;
    w_grant                   = {LANES{1'b0}};
    w_load                    = {LANES{1'b0}};
    w_wr_result               = {COUNT_BITS{1'b0}};
    w_wr_tag                  = {RAM_ADDR_BITS{1'b0}};
    w_wr_ovf                  = 1'b0;
    w_wr_sat                  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (w_wr_valid && (w_wr_sel.idx == 3'(k))) begin
        w_grant[k]  = 1'b1;
        w_wr_result = w_result[k];
        w_wr_tag    = w_tag[k];
        w_wr_ovf    = w_ovf[k];
        w_wr_sat    = w_sat[k];
      end else begin
        w_grant[k] = 1'b0;
      end
      if (w_dispatch && (w_disp_sel.idx == 3'(k))) begin
        w_load[k] = 1'b1;
      end else begin
        w_load[k] = 1'b0;
      end
    end
  end

  // Top state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= TOP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Top next-state: go edge starts, last write finishes, FIN lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TOP_IDLE: begin
        if (w_go_rise) begin
          w_state_nxt = TOP_RUN;
        end else begin
          w_state_nxt = TOP_IDLE;
        end
      end
      TOP_RUN: begin
        if (w_last_write) begin
          w_state_nxt = TOP_FIN;
        end else begin
          w_state_nxt = TOP_RUN;
        end
      end
      TOP_FIN: begin
        w_state_nxt = TOP_IDLE;
      end
      default: begin
        w_state_nxt = TOP_IDLE;
      end
    endcase
  end

  // Sweep bookkeeping: go edge detect, index, write count, max tracker, flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_go_q      <= 1'b1;
      r_base      <= {N_BITS{1'b0}};
      r_idx       <= {IDX_BITS{1'b0}};
      r_wr_cnt    <= {IDX_BITS{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_saturated <= 1'b0;
      r_max_count <= {COUNT_BITS{1'b0}};
      r_max_start <= {N_BITS{1'b0}};
    end else begin
      r_go_q <= i_go;
      r_busy <= (w_state_nxt != TOP_IDLE);
      if ((r_state == TOP_IDLE) && w_go_rise) begin
        r_base      <= i_start;
        r_idx       <= {IDX_BITS{1'b0}};
        r_wr_cnt    <= {IDX_BITS{1'b0}};
        r_done      <= 1'b0;
        r_overflow  <= 1'b0;
        r_saturated <= 1'b0;
        r_max_count <= {COUNT_BITS{1'b0}};
        r_max_start <= {N_BITS{1'b0}};
      end else begin
        if (w_dispatch) begin
          r_idx <= r_idx + IDX_BITS'(1);
        end else begin
          r_idx <= r_idx;
        end
        if (w_wr_valid) begin
          r_wr_cnt    <= r_wr_cnt + IDX_BITS'(1);
          r_overflow  <= r_overflow | w_wr_ovf;
          r_saturated <= r_saturated | w_wr_sat;
          // strict compare: on a tie the earlier writer keeps the title
          if (w_wr_result > r_max_count) begin
            r_max_count <= w_wr_result;
            r_max_start <= r_base + N_BITS'(w_wr_tag);
          end else begin
            r_max_count <= r_max_count;
          end
        end else begin
          r_wr_cnt <= r_wr_cnt;
        end
        if (r_state == TOP_FIN) begin
          r_done <= 1'b1;
        end else begin
          r_done <= r_done;
        end
      end
    end
  end

  // Lane occupancy: taken on dispatch, released when its result is written
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lane_busy <= {LANES{1'b0}};
    end else begin
      r_lane_busy <= (r_lane_busy & ~w_grant) | w_load;
    end
  end

  // Count RAM write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wr_valid) begin
      r_mem[w_wr_tag] <= w_wr_result;
    end
  end

  // Registered read port; a same-cycle write is not forwarded
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= {COUNT_BITS{1'b0}};
    end else if ({1'b0, i_rd_addr} < WORDS_L) begin
      r_count <= r_mem[i_rd_addr];
    end else begin
      r_count <= {COUNT_BITS{1'b0}};
    end
  end

  // Drive outputs from registers
  always_comb begin
    o_count     = r_count;
    o_busy      = r_busy;
    o_done      = r_done;
    o_max_count = r_max_count;
    o_max_start = r_max_start;
    o_overflow  = r_overflow;
    o_saturated = r_saturated;
  end

endmodule
